ram_bank: RTL and testbench
===========================

// Module: ram_bank
// PURPOSE
//  Single-clock simple-dual-port RAM (1 write, 1 read port), successor to the flat debug RAM.
//  Adds byte enables, registered reads with valid, and a multi-cycle clear sweep in place of an
//  array-wide async reset. Optional per-byte parity. Sits behind the UART/test-harness data path
//  as scratch/buffer memory; exposes a combinational debug peek port for the harness.
// PARAMETERS
//  ADDR_WIDTH  4   address bits; DEPTH = 2**ADDR_WIDTH entries
//  DATA_WIDTH  32  word width; must be a multiple of 8; BYTES = DATA_WIDTH/8
// PORTS
//  clk       in   1           clock, all logic on posedge
//  rst_l     in   1           asynchronous, active-low reset
//  clr_req   in   1           request a full-array zero sweep (sampled when ready=1)
//  ready     out  1           1 = accesses accepted this cycle
//  wr_en     in   1           write strobe
//  wr_addr   in   ADDR_WIDTH  write address
//  wr_be     in   BYTES       byte enables; bit i covers wr_data[8i+7:8i]
//  wr_data   in   DATA_WIDTH  write data
//  par_inj   in   1           parity error injection (RAM_BANK_PARITY_EN only; else ignored)
//  rd_en     in   1           read strobe
//  rd_addr   in   ADDR_WIDTH  read address
//  rd_data   out  DATA_WIDTH  read data, valid with rd_valid
//  rd_valid  out  1           pulses 1 cycle after an accepted read
//  par_err   out  1           parity mismatch on this rd_valid (0 without macro)
//  dbg_addr  in   ADDR_WIDTH  debug peek address
//  dbg_data  out  DATA_WIDTH  combinational mem[dbg_addr]
// BEHAVIOUR
//  - Reset: ready=0, rd_valid=0, rd_data=0, par_err=0, sweep counter=0, state=S_CLEAR.
//    Array itself has no reset; it is zeroed by the sweep.
//  - FSM: S_CLEAR -> writes 0 (and matching parity) to mem[cnt], one entry/cycle, cnt++;
//    at cnt==DEPTH-1 -> S_READY next cycle. S_READY -> S_CLEAR when clr_req=1, cnt=0.
//    Sweep always takes exactly DEPTH cycles; ready = (state==S_READY), registered.
//  - In S_CLEAR: wr_en, rd_en, clr_req ignored; no rd_valid generated.
//  - clr_req in S_READY with wr_en/rd_en same cycle: accesses complete first (write commits,
//    read returns next cycle), sweep starts next cycle.
//  - rst_l asserted mid-sweep or mid-operation: counter restarts at 0, full sweep repeats.
//  - Write: mem[wr_addr] byte i <= wr_data byte i where wr_be[i]; wr_be=0 is a no-op.
//  - Read: latency 1. Cycle N rd_en accepted -> cycle N+1 rd_valid=1, rd_data=word.
//    rd_data holds its last value while rd_valid=0.
//  - Read/write same address same cycle: write-first, byte-merged (new bytes where wr_be set,
//    old bytes elsewhere).
//  - dbg_data reflects array contents after last clock edge; no forwarding.
// CONFIGURATION
//  RAM_BANK_PARITY_EN defined: array stores BYTES extra even-parity bits; write computes parity
//   per enabled byte; par_inj=1 inverts stored parity of byte 0 on that write. On read,
//   par_err=1 with rd_valid if any byte parity mismatches (forwarded bytes use fresh parity).
//  Not defined: no parity storage, par_inj ignored, par_err tied 0.
// STRUCTURE
//  ram_bank_pkg: state enum {S_CLEAR, S_READY}, localparams BYTES/DEPTH helper functions,
//   byte-parity function.
//  Sub-module ram_bank_sweep: clear-address counter + done flag (start, cnt, last).
// TESTING
//  1 Release rst_l, ADDR_WIDTH=4 -> ready=0 for 16 cycles, then 1; dbg peek all 0.
//  2 Write 0xDEADBEEF @3 be=F, then be=0010b data 0x00005500 -> read @3 next cycle = 0xDEAD55EF.
//  3 Write 0x12345678 @5 and read @5 same cycle (old=0) be=0011b -> rd_data=0x00005678.
//  4 clr_req with write 0xA5A5A5A5 @7 -> ready low 16 cycles, then read @7 = 0.
//  5 Assert rst_l at sweep cycle 8 -> after release full 16-cycle sweep before ready.
//  6 PARITY_EN: write @2 par_inj=1 -> read @2 par_err=1; rewrite par_inj=0 -> par_err=0.

Source files
------------

// File: rtl/ram_bank_pkg.sv
// Shared types and helpers for the ram_bank scratch memory.
// Parity storage is enabled by defining RAM_BANK_PARITY_EN.
package ram_bank_pkg;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    function automatic int bytes_of(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Even parity: stored bit makes the total count of ones even.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/ram_bank_sweep.sv
// Clear-sweep address counter for ram_bank; last flags the final entry.
module ram_bank_sweep #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_l,
    input  logic                  start,
    input  logic                  en,
    output logic [ADDR_WIDTH-1:0] cnt,
    output logic                  last
);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (en) begin
            // Wraps back to 0 after the last entry, so the next sweep starts clean.
            cnt <= cnt + 1'b1;
        end
    end

    assign last = (cnt == {ADDR_WIDTH{1'b1}});

endmodule

// File: rtl/ram_bank.sv
// Simple-dual-port RAM with byte enables, registered reads and a clear sweep.
// Optional per-byte even parity when RAM_BANK_PARITY_EN is defined.
module ram_bank
    import ram_bank_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_l,
    input  logic                    clr_req,
    output logic                    ready,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    par_inj,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    par_err,
    input  logic [ADDR_WIDTH-1:0]   dbg_addr,
    output logic [DATA_WIDTH-1:0]   dbg_data
);

    localparam int BYTES = bytes_of(DATA_WIDTH);
    localparam int DEPTH = depth_of(ADDR_WIDTH);

    state_t                  state_q, state_d;
    logic                    sweep_start, sweep_en, sweep_last;
    logic [ADDR_WIDTH-1:0]   sweep_cnt;
    logic                    wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    ram_bank_sweep #(.ADDR_WIDTH(ADDR_WIDTH)) u_sweep (
        .clk   (clk),
        .rst_l (rst_l),
        .start (sweep_start),
        .en    (sweep_en),
        .cnt   (sweep_cnt),
        .last  (sweep_last)
    );

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= S_CLEAR;
            ready   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready   <= (state_d == S_READY);
        end
    end

    always_comb begin
        state_d     = state_q;
        sweep_start = 1'b0;
        sweep_en    = 1'b0;
        case (state_q)
            S_CLEAR: begin
                sweep_en = 1'b1;
                if (sweep_last) state_d = S_READY;
            end
            S_READY: begin
                if (clr_req) begin
                    state_d     = S_CLEAR;
                    sweep_start = 1'b1;
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    // ready mirrors S_READY, so accesses issued alongside clr_req still complete.
    assign wr_acc = ready && wr_en;
    assign rd_acc = ready && rd_en;

    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            mem[sweep_cnt] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < BYTES; i++) begin
                if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // Write-first: bytes being written this cycle bypass the array.
    always_comb begin
        rd_word = mem[rd_addr];
        for (int i = 0; i < BYTES; i++) begin
            if (wr_acc && (wr_addr == rd_addr) && wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) rd_data <= rd_word;
        end
    end

    assign dbg_data = mem[dbg_addr];

`ifdef RAM_BANK_PARITY_EN
    logic [BYTES-1:0] mem_par [DEPTH];
    logic [BYTES-1:0] wr_par, rd_par, rd_chk;

    always_comb begin
        wr_par = '0;
        for (int i = 0; i < BYTES; i++) wr_par[i] = byte_parity(wr_data[8*i +: 8]);
        wr_par[0] = wr_par[0] ^ par_inj;
    end

    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            mem_par[sweep_cnt] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < BYTES; i++) begin
                if (wr_be[i]) mem_par[wr_addr][i] <= wr_par[i];
            end
        end
    end

    // Forwarded bytes carry the parity being written alongside them.
    always_comb begin
        rd_par = mem_par[rd_addr];
        rd_chk = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (wr_acc && (wr_addr == rd_addr) && wr_be[i]) rd_par[i] = wr_par[i];
            rd_chk[i] = byte_parity(rd_word[8*i +: 8]);
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            par_err <= 1'b0;
        end else begin
            par_err <= rd_acc && (|(rd_par ^ rd_chk));
        end
    end
`else
    logic unused_par_inj;
    assign unused_par_inj = par_inj;
    assign par_err        = 1'b0;
`endif

endmodule

// File: tb/tb_ram_bank.sv
// Directed bench for ram_bank (ADDR_WIDTH=4, DATA_WIDTH=32).
module tb_ram_bank;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        clr_req;
    logic        ready;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        par_inj;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        par_err;
    logic [3:0]  dbg_addr;
    logic [31:0] dbg_data;

    int n_vec = 0;
    int n_err = 0;

    ram_bank #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
        .clk      (clk),
        .rst_l    (rst_l),
        .clr_req  (clr_req),
        .ready    (ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_be    (wr_be),
        .wr_data  (wr_data),
        .par_inj  (par_inj),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .par_err  (par_err),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clr_req = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_be   = '0;
        wr_data = '0;
        par_inj = 1'b0;
        rd_en   = 1'b0;
        rd_addr = '0;
        dbg_addr = '0;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_be = be; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] a);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic peek(input string tag, input logic [3:0] a, input logic [31:0] exp);
        dbg_addr = a;
        #1;
        n_vec++;
        if (dbg_data !== exp) begin
            n_err++;
            $display("FAIL %s dbg[%0d]: got %h expected %h", tag, a, dbg_data, exp);
        end
    endtask

    task automatic check_read(input string tag, input logic [31:0] exp);
        n_vec++;
        if (rd_valid !== 1'b1 || rd_data !== exp) begin
            n_err++;
            $display("FAIL %s: got valid=%b data=%h expected valid=1 data=%h", tag, rd_valid, rd_data, exp);
        end
    endtask

    // Expects ready low for exactly 16 samples, then high.
    task automatic wait_sweep(input string tag);
        for (int i = 0; i < 16; i++) begin
            n_vec++;
            if (ready !== 1'b0 || rd_valid !== 1'b0) begin
                n_err++;
                $display("FAIL %s cycle %0d: got ready=%b rd_valid=%b expected 0/0", tag, i, ready, rd_valid);
            end
            tick();
        end
        n_vec++;
        if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s done: got ready=%b expected 1", tag, ready);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_l = 1'b0;
        tick();
        tick();
        n_vec++;
        if (ready !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 32'h0 || par_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got ready=%b rd_valid=%b rd_data=%h par_err=%b expected 0/0/0/0",
                     ready, rd_valid, rd_data, par_err);
        end
        rst_l = 1'b1;
        wait_sweep("reset_sweep");
        for (int a = 0; a < 16; a++) peek("reset_zero", 4'(a), 32'h0);
    endtask

    task automatic test_byte_enable();
        do_write(4'd3, 4'hF, 32'hDEADBEEF);
        do_write(4'd3, 4'b0010, 32'h00005500);
        do_read(4'd3);
        check_read("be_merge_read", 32'hDEAD55EF);
        tick();
        n_vec++;
        if (rd_valid !== 1'b0 || rd_data !== 32'hDEAD55EF) begin
            n_err++;
            $display("FAIL rd_hold: got valid=%b data=%h expected valid=0 data=deadbeef-merged %h",
                     rd_valid, rd_data, 32'hDEAD55EF);
        end
        do_write(4'd3, 4'h0, 32'hFFFFFFFF);
        peek("be_zero_noop", 4'd3, 32'hDEAD55EF);
    endtask

    task automatic test_write_first();
        wr_en = 1'b1; wr_addr = 4'd5; wr_be = 4'b0011; wr_data = 32'h12345678;
        rd_en = 1'b1; rd_addr = 4'd5;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        check_read("write_first", 32'h00005678);
        peek("write_first_mem", 4'd5, 32'h00005678);
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        vals[0] = 32'h01020304; vals[1] = 32'hCAFEF00D;
        vals[2] = 32'h80000001; vals[3] = 32'h7FFFFFFE;
        for (int i = 0; i < 4; i++) do_write(4'(10 + i), 4'hF, vals[i]);
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_addr = 4'(10 + i);
            tick();
            check_read("b2b_read", vals[i]);
        end
        rd_en = 1'b0;
        tick();
        n_vec++;
        if (rd_valid !== 1'b0 || rd_data !== vals[3]) begin
            n_err++;
            $display("FAIL b2b_end: got valid=%b data=%h expected valid=0 data=%h", rd_valid, rd_data, vals[3]);
        end
    endtask

    task automatic test_clear();
        clr_req = 1'b1;
        wr_en = 1'b1; wr_addr = 4'd7; wr_be = 4'hF; wr_data = 32'hA5A5A5A5;
        tick();
        peek("clr_write_commits", 4'd7, 32'hA5A5A5A5);
        // Everything below must be ignored during the sweep.
        wr_addr = 4'd0; wr_data = 32'hFFFFFFFF;
        rd_en = 1'b1; rd_addr = 4'd7;
        wait_sweep("clr_sweep");
        idle_inputs();
        peek("clr_ignored_write", 4'd0, 32'h0);
        do_read(4'd7);
        check_read("clr_read7", 32'h0);
    endtask

    task automatic test_reset_mid_sweep();
        do_write(4'd12, 4'hF, 32'h11223344);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (8) tick();
        peek("mid_sweep_untouched", 4'd12, 32'h11223344);
        rst_l = 1'b0;
        tick();
        n_vec++;
        if (ready !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_ready: got %b expected 0", ready);
        end
        rst_l = 1'b1;
        wait_sweep("mid_reset_sweep");
        peek("mid_reset_zero", 4'd12, 32'h0);
    endtask

    task automatic test_parity();
        logic exp_inj;
`ifdef RAM_BANK_PARITY_EN
        exp_inj = 1'b1;
`else
        exp_inj = 1'b0;
`endif
        par_inj = 1'b1;
        do_write(4'd2, 4'hF, 32'h0000000F);
        par_inj = 1'b0;
        do_read(4'd2);
        n_vec++;
        if (rd_valid !== 1'b1 || par_err !== exp_inj) begin
            n_err++;
            $display("FAIL parity_inj: got valid=%b par_err=%b expected 1/%b", rd_valid, par_err, exp_inj);
        end
        do_write(4'd2, 4'hF, 32'h0000000F);
        do_read(4'd2);
        n_vec++;
        if (rd_valid !== 1'b1 || par_err !== 1'b0 || rd_data !== 32'h0000000F) begin
            n_err++;
            $display("FAIL parity_clean: got valid=%b par_err=%b data=%h expected 1/0/0000000f",
                     rd_valid, par_err, rd_data);
        end
    endtask

    initial begin
        test_reset();
        test_byte_enable();
        test_write_first();
        test_back_to_back();
        test_clear();
        test_reset_mid_sweep();
        test_parity();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
